// File: rtl/sisc_pkg.sv
// Shared definitions for the sisc control unit: opcodes, FSM states,
// PC source encodings and IR field positions.
package sisc_pkg;

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h8;
  localparam logic [3:0] OP_BRR  = 4'h4;
  localparam logic [3:0] OP_BRA  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_REL = 2'd1;
  localparam logic [1:0] PC_ABS = 2'd2;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 28;
  localparam int MM_MSB   = 27;
  localparam int MM_LSB   = 24;
  localparam int FUNC_MSB = 3;
  localparam int FUNC_LSB = 0;

  // A zero mask is an unconditional branch; otherwise any masked flag set.
  function automatic logic br_taken(input logic [3:0] mm, input logic [3:0] st);
    return (mm == 4'h0) || (|(st & mm));
  endfunction

endpackage

// File: rtl/sisc_ctrl_dec.sv
// Combinational output decode of the control FSM state and the IR opcode
// fields, including the branch-taken evaluation against the ALU flags.
module sisc_ctrl_dec
  import sisc_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  input  logic [3:0] mm,
  input  logic [3:0] func,
  input  logic [3:0] stat,
  output logic       ir_load,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       imm_sel,
  output logic [3:0] alu_func,
  output logic       stat_en,
  output logic       rf_we,
  output logic       halted,
  output logic       taken
);

  logic w_is_branch;

  assign w_is_branch = (op == OP_BRR) || (op == OP_BRA);

  always_comb begin
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = PC_INC;
    imm_sel  = 1'b0;
    alu_func = 4'h0;
    stat_en  = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    taken    = 1'b0;

    case (state)
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        pc_sel   = PC_INC;
      end
      S_EXECUTE: begin
        if (op == OP_ALU) begin
          imm_sel  = mm[3];
          alu_func = func;
          stat_en  = 1'b1;
        end else if (w_is_branch && br_taken(mm, stat)) begin
          taken    = 1'b1;
          pc_write = 1'b1;
          pc_sel   = (op == OP_BRR) ? PC_REL : PC_ABS;
        end
      end
      S_WRITEBACK: begin
        // Operand select and function are held so the ALU result stays valid for the write.
        if (op == OP_ALU) begin
          rf_we    = 1'b1;
          imm_sel  = mm[3];
          alu_func = func;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/sisc_ctrl_fsm.sv
// Multi-cycle control unit for sisc: sequences each instruction through
// fetch/decode/execute/mem/writeback and drives the datapath enables.
//
// state     | meaning
// ----------+-----------------------------------------------
// START     | idle after reset, outputs quiet
// FETCH     | load IR, advance PC by one
// DECODE    | opcode inspected, HALT diverted here
// EXECUTE   | ALU op with flag latch, or conditional branch
// MEM       | memory access slot (no enables from this block)
// WRITEBACK | register-file write for ALU ops
// HALT      | stopped until reset
module sisc_ctrl_fsm
  import sisc_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_F,
  input  logic [31:0] IR,
  input  logic [3:0]  stat,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        imm_sel,
  output logic [3:0]  alu_func,
  output logic        stat_en,
  output logic        rf_we,
  output logic        halted
);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] w_op;
  logic [3:0] w_mm;
  logic [3:0] w_func;
  logic       w_taken;
  logic       w_unused;

  assign w_op     = IR[OP_MSB:OP_LSB];
  assign w_mm     = IR[MM_MSB:MM_LSB];
  assign w_func   = IR[FUNC_MSB:FUNC_LSB];
  // Register specifiers and the immediate are consumed by the datapath, not here.
  assign w_unused = ^{IR[23:4], w_taken};

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) r_state <= S_START;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_START:     w_next_state = S_FETCH;
      S_FETCH:     w_next_state = S_DECODE;
      S_DECODE:    w_next_state = (w_op == OP_HALT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   w_next_state = S_MEM;
      S_MEM:       w_next_state = S_WRITEBACK;
      S_WRITEBACK: w_next_state = S_FETCH;
      S_HALT:      w_next_state = S_HALT;
      default:     w_next_state = S_START;
    endcase
  end

  sisc_ctrl_dec u_dec (
    .state    (r_state),
    .op       (w_op),
    .mm       (w_mm),
    .func     (w_func),
    .stat     (stat),
    .ir_load  (ir_load),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .imm_sel  (imm_sel),
    .alu_func (alu_func),
    .stat_en  (stat_en),
    .rf_we    (rf_we),
    .halted   (halted),
    .taken    (w_taken)
  );

endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// Randomized bench for sisc_ctrl_fsm: instructions are streamed in and every
// cycle's outputs are compared with a cycle-position reference model.
module tb_sisc_ctrl_fsm;

  logic        CLK = 1'b0;
  logic        RST_F;
  logic [31:0] IR;
  logic [3:0]  stat;
  logic        ir_load, pc_write, imm_sel, stat_en, rf_we, halted;
  logic [1:0]  pc_sel;
  logic [3:0]  alu_func;

  sisc_ctrl_fsm dut (
    .CLK(CLK), .RST_F(RST_F), .IR(IR), .stat(stat),
    .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel),
    .imm_sel(imm_sel), .alu_func(alu_func), .stat_en(stat_en),
    .rf_we(rf_we), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  st;
    bit          fixed;
  } instr_t;

  instr_t q[$];
  instr_t cur;
  int     n_vec  = 0;
  int     n_miss = 0;
  // Model: cycle position within the current instruction (-1 = pre-fetch).
  int     pos;
  bit     stopped;
  bit     in_reset;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {ir_load,pc_write,pc_sel,imm_sel,alu_func,stat_en,rf_we,halted}.
  function automatic logic [11:0] expect_outs(input int p, input bit h,
                                              input logic [31:0] ir, input logic [3:0] st);
    logic [3:0] op, mm;
    logic ild, pcw, ims, sen, rfw;
    logic [1:0] psel;
    logic [3:0] fn;
    op = ir[31:28]; mm = ir[27:24];
    ild = 0; pcw = 0; ims = 0; sen = 0; rfw = 0; psel = 0; fn = 0;
    if (h) return 12'h001;
    if (p == 0) begin
      ild = 1; pcw = 1;
    end else if (p == 2) begin
      if (op == 4'h8) begin
        ims = mm[3]; fn = ir[3:0]; sen = 1;
      end else if ((op == 4'h4 || op == 4'h5) && (mm == 0 || (st & mm) != 0)) begin
        pcw = 1; psel = (op == 4'h4) ? 2'd1 : 2'd2;
      end
    end else if (p == 4 && op == 4'h8) begin
      rfw = 1; ims = mm[3]; fn = ir[3:0];
    end
    return {ild, pcw, psel, ims, fn, sen, rfw, 1'b0};
  endfunction

  task automatic tick();
    @(posedge CLK);
    if (!in_reset && !stopped) begin
      if (pos == -1) pos = 0;
      else if (pos == 1 && cur.ir[31:28] == 4'hF) stopped = 1;
      else pos = (pos + 1) % 5;
    end
    #1;
    chk("outs", {ir_load, pc_write, pc_sel, imm_sel, alu_func, stat_en, rf_we, halted},
        in_reset ? 32'h0 : {20'h0, expect_outs(pos, stopped, cur.ir, stat)});
    if (!in_reset && !stopped && pos == 0) begin
      if (q.size() > 0) cur = q.pop_front();
      else begin cur.ir = 32'h0; cur.st = 4'h0; cur.fixed = 0; end
      IR = cur.ir;
    end
    stat = cur.fixed ? cur.st : 4'($urandom);
  endtask

  task automatic push(input logic [31:0] ir, input logic [3:0] st, input bit fixed);
    instr_t t;
    t.ir = ir; t.st = st; t.fixed = fixed;
    q.push_back(t);
  endtask

  task automatic drain();
    int guard = 0;
    while (!stopped && !(q.size() == 0 && pos == 4)) begin
      tick();
      guard++;
      if (guard > 5000) begin
        chk("drain_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic do_reset();
    RST_F = 1'b0;
    in_reset = 1; stopped = 0; pos = -1;
    #1;
    chk("reset_async", {ir_load, pc_write, pc_sel, imm_sel, alu_func, stat_en, rf_we, halted}, 32'h0);
    repeat (2) tick();
    @(negedge CLK);
    RST_F = 1'b1;
    in_reset = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [3:0]  ops [6];
    ops = '{4'h0, 4'h8, 4'h4, 4'h5, 4'h3, 4'h0};
    r = $urandom;
    ops[5] = 4'($urandom_range(0, 14));
    r[31:28] = ops[$urandom_range(0, 5)];
    return r;
  endfunction

  initial begin
    int guard;
    RST_F = 1'b0; IR = 32'h0; stat = 4'h0;
    cur.ir = 32'h0; cur.st = 4'h0; cur.fixed = 0;
    pos = -1; stopped = 0; in_reset = 1;
    #2;
    do_reset();

    push(32'h8802000A, 4'h0, 0);
    push(32'h80231002, 4'h0, 0);
    push(32'h41000005, 4'b0001, 1);
    push(32'h41000005, 4'b0000, 1);
    push(32'h50000020, 4'b0000, 1);
    push(32'h50000020, 4'($urandom), 0);
    push(32'h30000000, 4'hF, 1);
    drain();

    // Reset mid-EXECUTE of an ALU op.
    push(32'h8802000A, 4'h0, 0);
    guard = 0;
    while (!(pos == 2 && cur.ir == 32'h8802000A) && guard < 100) begin tick(); guard++; end
    chk("reach_execute", (guard < 100) ? 32'd1 : 32'd0, 32'd1);
    #2;
    do_reset();
    tick();
    chk("first_fetch", {ir_load, pc_write}, 32'd3);

    for (int i = 0; i < 200; i++) push(rand_instr(), 4'h0, 0);
    drain();

    push(32'h80231002, 4'h0, 0);
    push(32'h41000005, 4'b0000, 1);
    push(32'hF0000000, 4'h0, 0);
    drain();
    chk("halted", {31'h0, halted}, 32'd1);
    repeat (20) tick();
    chk("halt_no_fetch", {ir_load, pc_write}, 32'd0);
    #2;
    do_reset();
    chk("halted_cleared", {31'h0, halted}, 32'd0);
    tick();
    chk("fetch_after_halt", {ir_load, pc_write}, 32'd3);
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
